// File: rtl/prefix_add_arbiter.sv
// prefix_add_arbiter: round-robin arbiter that shares one 8-bit prefix adder
// among NREQ operand requesters. The result goes into a single-entry output slot.
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is the combinational grant)
//   req_a, req_b          packed 8-bit operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready   output slot handshake
//   rsp_id, rsp_sum, rsp_cout  registered result tagged with the owning requester

// gptprefix8_l4: 8-bit Kogge-Stone prefix adder.
//   a, b   operands
//   cin    carry in
//   sum    a+b+cin mod 256
//   cout   carry out of bit 7
module gptprefix8_l4 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g0, p0, g1, p1, g2, p2, g3;

    // Carry-in is folded into bit 0 generate, so g3[i] is the carry out of bit i
    always_comb begin : prefix_tree
        p0    = a ^ b;
        g0    = a & b;
        g0[0] = g0[0] | (p0[0] & cin);

        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end

        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end

        g3 = g2;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end

        sum  = p0 ^ {g3[6:0], cin};
        cout = g3[7];
    end

endmodule

module prefix_add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_sum,
    output logic              rsp_cout
);

    localparam int unsigned DW = 8;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic           accept;
    logic           grant;
    logic [DW-1:0]  a_sel, b_sel, add_sum;
    logic           add_cout;

    // Round-robin scan starting at ptr_q, wrapping modulo NREQ
    always_comb begin : rr_scan
        logic [IDW:0] idx_w;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        idx_w     = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NREQ)) begin
                idx_w = idx_w - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[idx_w[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_w[IDW-1:0];
            end
        end
    end

    // Slot can take a new result when empty or when it drains this cycle
    assign accept    = (state_q == ST_EMPTY) | rsp_ready;
    assign grant     = rst_n & accept & gnt_found;
    assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

    // Winner's operands feed the shared adder
    assign a_sel = req_a[{gnt_idx, 3'b000} +: DW];
    assign b_sel = req_b[{gnt_idx, 3'b000} +: DW];

    gptprefix8_l4 u_adder (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Slot occupancy next state; a grant wins over a drain
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (grant)          state_d = ST_FULL;
                else if (rsp_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Round-robin pointer moves past the winner only on a grant
    always_ff @(posedge clk) begin : ptr_reg
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant) begin
            if (gnt_idx == IDW'(NREQ - 1)) ptr_q <= '0;
            else                           ptr_q <= gnt_idx + IDW'(1);
        end
    end

    // Output slot: load on grant, clear on drain, otherwise hold
    always_ff @(posedge clk) begin : slot_reg
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prefix_add_arbiter.sv
// tb_prefix_add_arbiter: directed self-checking bench for prefix_add_arbiter
// with a result scoreboard and a round-robin grant model.
module tb_prefix_add_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_sum;
    logic              rsp_cout;

    logic [7:0] opa [NREQ];
    logic [7:0] opb [NREQ];

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     sum;
        logic           cout;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_ptr    = 0;
    int   last_g   = -1;
    int   rr_ids [8];
    logic [7:0] held_sum;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = opa[i];
            req_b[8*i +: 8] = opb[i];
        end
    end

    prefix_add_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, return 1 time unit after the rising edge
    task automatic cycle();
        bit   accept;
        int   g;
        logic [8:0] full;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            chk("req_ready_in_reset", 32'(req_ready), 32'd0);
            sb.delete();
            m_ptr  = 0;
            last_g = -1;
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
            accept = (sb.size() == 0) || rsp_ready;
            if (sb.size() != 0) begin
                chk("rsp_id",   32'(rsp_id),   32'(sb[0].id));
                chk("rsp_sum",  32'(rsp_sum),  32'(sb[0].sum));
                chk("rsp_cout", 32'(rsp_cout), 32'(sb[0].cout));
                if (rsp_ready) void'(sb.pop_front());
            end
            g = -1;
            if (accept) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            last_g = g;
            if (g >= 0) begin
                full   = {1'b0, opa[g]} + {1'b0, opb[g]};
                e.id   = IDW'(g);
                e.sum  = full[7:0];
                e.cout = full[8];
                sb.push_back(e);
                m_ptr = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 8'(8'h11 * (i + 1));
            opb[i] = 8'(8'h0F + 8'h20 * i);
        end

        // 1. Reset with every requester asking
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        cycle();
        cycle();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(rsp_id),    32'd0);
        chk("reset_rsp_sum",   32'(rsp_sum),   32'd0);
        chk("reset_rsp_cout",  32'(rsp_cout),  32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        chk("first_grant", 32'(last_g), 32'd0);
        req_valid = 4'b0000;
        cycle();

        // 2. Single request from requester 2
        opa[2]    = 8'h5A;
        opb[2]    = 8'h3C;
        req_valid = 4'b0100;
        cycle();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id",    32'(rsp_id),    32'd2);
        chk("single_sum",   32'(rsp_sum),   32'h96);
        chk("single_cout",  32'(rsp_cout),  32'd0);
        req_valid = 4'b0000;
        cycle();

        // 3. Round-robin: move ptr to 0 via requester 3, then all request for 8 cycles
        req_valid = 4'b1000;
        cycle();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            rr_ids[k] = last_g;
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_grant_%0d", k), 32'(rr_ids[k]), 32'(k % 4));
        end

        // 4. Backpressure: slot holds requester 3's result
        rsp_ready = 1'b0;
        held_sum  = rsp_sum;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("hold_id",  32'(rsp_id),  32'd3);
            chk("hold_sum", 32'(rsp_sum), 32'(held_sum));
            chk("hold_no_grant", 32'(last_g), 32'hFFFF_FFFF);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("drain_regrant", 32'(last_g), 32'd0);
        chk("drain_regrant_valid", 32'(rsp_valid), 32'd1);
        chk("drain_regrant_id",    32'(rsp_id),    32'd0);
        req_valid = 4'b0000;
        cycle();

        // 5. Carry boundaries, back to back on requester 1
        req_valid = 4'b0010;
        opa[1] = 8'hFF; opb[1] = 8'h01;
        cycle();
        chk("carry_ff01_sum",  32'(rsp_sum),  32'h00);
        chk("carry_ff01_cout", 32'(rsp_cout), 32'd1);
        opa[1] = 8'hFF; opb[1] = 8'hFF;
        cycle();
        chk("carry_ffff_sum",  32'(rsp_sum),  32'hFE);
        chk("carry_ffff_cout", 32'(rsp_cout), 32'd1);
        opa[1] = 8'h00; opb[1] = 8'h00;
        cycle();
        chk("carry_0000_sum",  32'(rsp_sum),  32'h00);
        chk("carry_0000_cout", 32'(rsp_cout), 32'd0);
        req_valid = 4'b0000;
        cycle();

        // 6. Mid-operation reset with a full slot and ptr at 3
        rsp_ready = 1'b0;
        opa[2] = 8'h10; opb[2] = 8'h20;
        req_valid = 4'b0100;
        cycle();
        chk("pre_reset_grant", 32'(last_g), 32'd2);
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        cycle();
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_rsp_sum",   32'(rsp_sum),   32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        chk("post_reset_grant", 32'(last_g), 32'd0);
        req_valid = 4'b0000;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
